// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, fault codes,
// RISC-V load/store funct3 encodings and the MMIO register map.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD_ISSUE,
    LOAD_CAPTURE,
    RESP
  } lsu_state_t;

  localparam logic [1:0] FAULT_NONE       = 2'd0;
  localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
  localparam logic [1:0] FAULT_ACCESS     = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] MMIO_LEDS   = 32'hFFFF_FFFC;
  localparam logic [31:0] MMIO_MILLIS = 32'hFFFF_FFF8;
  localparam logic [31:0] MMIO_MICROS = 32'hFFFF_FFF4;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational classifier for one access: illegal funct3, misalignment and
// address-map violations, reported in priority order as a fault code.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_SIZE_BYTES = 4096
) (
  input  logic [31:0] ea,
  input  logic [2:0]  funct3,
  input  logic        is_store,
  output logic [1:0]  fault
);

  logic illegal;
  logic misaligned;
  logic in_ram;
  logic in_mmio;
  logic read_only;

  // Stores only have SB/SH/SW; loads additionally have the unsigned forms.
  assign illegal = is_store ? (funct3[2] || (funct3 == 3'b011))
                            : ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111));

  assign misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                      ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

  assign in_ram    = ea < 32'(DMEM_SIZE_BYTES);
  assign in_mmio   = ea >= MMIO_MICROS;
  // The millis/micros timers occupy the MMIO words below the LED register.
  assign read_only = is_store && in_mmio && (ea < MMIO_LEDS);

  always_comb begin
    fault = FAULT_NONE;
    if (illegal) begin
      fault = FAULT_ACCESS;
    end else if (misaligned) begin
      fault = FAULT_MISALIGNED;
    end else if (!(in_ram || in_mmio) || read_only) begin
      fault = FAULT_ACCESS;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Core-side load/store initiator: one request at a time, drives the dmem port,
// captures synchronous read data and returns one response per request.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DMEM_SIZE_BYTES = 4096,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_is_store,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_base,
  input  logic [31:0]          req_offset,
  input  logic [31:0]          req_store_data,
  input  logic [4:0]           req_rd,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [4:0]           rsp_rd,
  output logic [1:0]           rsp_fault,
  output logic [31:0]          rsp_fault_addr,
  output logic [31:0]          dmem_address,
  output logic [2:0]           dmem_funct3,
  output logic                 dmem_wren,
  output logic [31:0]          dmem_data_in,
  input  logic [31:0]          dmem_data_out,
  output logic [CNT_WIDTH-1:0] load_count,
  output logic [CNT_WIDTH-1:0] store_count,
  output logic [CNT_WIDTH-1:0] fault_count
);

  lsu_state_t  state;
  lsu_state_t  next_state;
  logic [31:0] ea;
  logic [1:0]  req_fault;
  logic        accept;
  logic        handshake;
  logic        kind_store;

  assign ea        = req_base + req_offset;
  assign accept    = req_valid && req_ready;
  assign handshake = rsp_valid && rsp_ready;

  lsu_addr_check #(
    .DMEM_SIZE_BYTES(DMEM_SIZE_BYTES)
  ) u_addr_check (
    .ea       (ea),
    .funct3   (req_funct3),
    .is_store (req_is_store),
    .fault    (req_fault)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_fault != FAULT_NONE) begin
            next_state = RESP;
          end else if (req_is_store) begin
            next_state = STORE;
          end else begin
            next_state = LOAD_ISSUE;
          end
        end
      end
      STORE:        next_state = RESP;
      LOAD_ISSUE:   next_state = LOAD_CAPTURE;
      LOAD_CAPTURE: next_state = RESP;
      RESP:         if (rsp_ready) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Faulting requests leave the dmem address/funct3/data untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_wren      <= 1'b0;
      dmem_address   <= '0;
      dmem_funct3    <= '0;
      dmem_data_in   <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_rd         <= '0;
      rsp_fault      <= FAULT_NONE;
      rsp_fault_addr <= '0;
      kind_store     <= 1'b0;
      load_count     <= '0;
      store_count    <= '0;
      fault_count    <= '0;
    end else begin
      dmem_wren <= (next_state == STORE);
      rsp_valid <= (next_state == RESP);
      if (accept) begin
        rsp_rd         <= req_rd;
        rsp_fault      <= req_fault;
        rsp_fault_addr <= ea;
        rsp_data       <= '0;
        kind_store     <= req_is_store;
        if (req_fault == FAULT_NONE) begin
          dmem_address <= ea;
          dmem_funct3  <= req_funct3;
          dmem_data_in <= req_store_data;
        end
      end
      if (state == LOAD_CAPTURE) begin
        rsp_data <= dmem_data_out;
      end
      // Counters stick at all-ones instead of wrapping.
      if (handshake) begin
        if (rsp_fault != FAULT_NONE) begin
          if (~&fault_count) fault_count <= fault_count + 1'b1;
        end else if (kind_store) begin
          if (~&store_count) store_count <= store_count + 1'b1;
        end else begin
          if (~&load_count) load_count <= load_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// data-memory/MMIO responder (one-cycle synchronous read, formatted loads).
module tb_load_store_unit;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_base;
  logic [31:0]   req_offset;
  logic [31:0]   req_store_data;
  logic [4:0]    req_rd;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [4:0]    rsp_rd;
  logic [1:0]    rsp_fault;
  logic [31:0]   rsp_fault_addr;
  logic [31:0]   dmem_address;
  logic [2:0]    dmem_funct3;
  logic          dmem_wren;
  logic [31:0]   dmem_data_in;
  logic [31:0]   dmem_data_out;
  logic [CW-1:0] load_count;
  logic [CW-1:0] store_count;
  logic [CW-1:0] fault_count;

  int checks = 0;
  int failures = 0;
  int wrenCycles = 0;
  logic [31:0] wrenAddr = '0;

  int          lat;
  logic [31:0] gotData;
  logic [31:0] gotAddr;
  logic [1:0]  gotFault;
  logic [4:0]  gotRd;

  logic [7:0]  ram [0:4095];
  logic [31:0] leds = '0;

  // A 4-bit counter width keeps the saturation check within a short run.
  load_store_unit #(
    .DMEM_SIZE_BYTES(4096),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_fault(rsp_fault), .rsp_fault_addr(rsp_fault_addr),
    .dmem_address(dmem_address), .dmem_funct3(dmem_funct3), .dmem_wren(dmem_wren),
    .dmem_data_in(dmem_data_in), .dmem_data_out(dmem_data_out),
    .load_count(load_count), .store_count(store_count), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] byteAt(input logic [31:0] a);
    logic [31:0] w;
    if (a >= 32'hFFFF_FFF4) begin
      case (a[3:2])
        2'd3:    w = leds;
        2'd2:    w = 32'h0000_1234;
        default: w = 32'h0005_6789;
      endcase
      return w[8*a[1:0] +: 8];
    end
    return ram[a[11:0]];
  endfunction

  function automatic logic [31:0] loadFmt(input logic [31:0] a, input logic [2:0] f3);
    logic [7:0] b0, b1, b2, b3;
    b0 = byteAt(a);
    b1 = byteAt(a + 32'd1);
    b2 = byteAt(a + 32'd2);
    b3 = byteAt(a + 32'd3);
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b100:  return {24'd0, b0};
      3'b101:  return {16'd0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic setByte(input logic [31:0] a, input logic [7:0] b);
    if (a >= 32'hFFFF_FFFC) leds[8*a[1:0] +: 8] = b;
    else if (a < 32'd4096) ram[a[11:0]] = b;
  endtask

  // Responder: read data reflects the address presented in the previous cycle.
  always @(posedge clk) begin
    dmem_data_out <= loadFmt(dmem_address, dmem_funct3);
    if (dmem_wren) begin
      setByte(dmem_address, dmem_data_in[7:0]);
      if (dmem_funct3[1:0] != 2'b00) setByte(dmem_address + 32'd1, dmem_data_in[15:8]);
      if (dmem_funct3[1:0] == 2'b10) begin
        setByte(dmem_address + 32'd2, dmem_data_in[23:16]);
        setByte(dmem_address + 32'd3, dmem_data_in[31:24]);
      end
    end
  end

  always @(negedge clk) begin
    if (dmem_wren) begin
      wrenCycles = wrenCycles + 1;
      wrenAddr   = dmem_address;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request, waits for its acceptance and for rsp_valid,
  // leaving the response fields and latency in gotData/gotFault/gotRd/lat.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] base,
                               input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    req_valid      = 1'b1;
    req_is_store   = st;
    req_funct3     = f3;
    req_base       = base;
    req_offset     = off;
    req_store_data = sd;
    req_rd         = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 32'd0, 32'd1);
    gotData  = rsp_data;
    gotFault = rsp_fault;
    gotRd    = rsp_rd;
    gotAddr  = rsp_fault_addr;
  endtask

  task automatic checkRsp(input string tag, input int expLat, input logic [1:0] expFault,
                          input logic [31:0] expData, input logic [4:0] expRd);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_fault"}, 32'(gotFault), 32'(expFault));
    checkOutput({tag, "_data"}, gotData, expData);
    checkOutput({tag, "_rd"}, 32'(gotRd), 32'(expRd));
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    reset_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_base = '0; req_offset = '0; req_store_data = '0; req_rd = '0; rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_dmem_wren", 32'(dmem_wren), 32'd0);
    checkOutput("reset_dmem_address", dmem_address, 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_counters", {load_count, store_count, fault_count}, 32'd0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;

    // Word store then load at 0x104.
    w0 = wrenCycles;
    applyStimulus(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF, 5'd1);
    checkRsp("sw_104", 2, 2'd0, 32'h0, 5'd1);
    checkOutput("sw_104_wren_cycles", 32'(wrenCycles - w0), 32'd1);
    checkOutput("sw_104_wren_addr", wrenAddr, 32'h104);
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd2);
    checkRsp("lw_104", 3, 2'd0, 32'hDEADBEEF, 5'd2);
    settle();
    checkOutput("cnt_after_sw_lw", {load_count, store_count, fault_count}, {20'd0, 4'd1, 4'd1, 4'd0});

    // Byte store and signed/unsigned byte loads.
    applyStimulus(1'b1, 3'b000, 32'h200, 32'h3, 32'h12345680, 5'd3);
    checkRsp("sb_203", 2, 2'd0, 32'h0, 5'd3);
    applyStimulus(1'b0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd4);
    checkRsp("lb_203", 3, 2'd0, 32'hFFFFFF80, 5'd4);
    applyStimulus(1'b0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd5);
    checkRsp("lbu_203", 3, 2'd0, 32'h00000080, 5'd5);
    applyStimulus(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 5'd6);
    checkRsp("lw_200", 3, 2'd0, 32'h80000000, 5'd6);
    applyStimulus(1'b0, 3'b010, 32'h114, 32'hFFFFFFF0, 32'h0, 5'd7);
    checkRsp("lw_neg_offset", 3, 2'd0, 32'hDEADBEEF, 5'd7);

    // Misaligned accesses never reach the memory.
    w0 = wrenCycles;
    applyStimulus(1'b0, 3'b010, 32'h100, 32'h2, 32'h0, 5'd8);
    checkRsp("lw_102", 1, 2'd1, 32'h0, 5'd8);
    applyStimulus(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 5'd9);
    checkRsp("lh_101", 1, 2'd1, 32'h0, 5'd9);
    checkOutput("misaligned_wren_cycles", 32'(wrenCycles - w0), 32'd0);
    settle();
    checkOutput("fault_count_2", 32'(fault_count), 32'd2);

    // Address map and MMIO.
    applyStimulus(1'b1, 3'b010, 32'hFFFFFFF0, 32'h8, 32'h55, 5'd10);
    checkRsp("sw_millis_ro", 1, 2'd2, 32'h0, 5'd10);
    applyStimulus(1'b1, 3'b010, 32'h0, 32'hFFFFFFFC, 32'h11223344, 5'd11);
    checkRsp("sw_leds", 2, 2'd0, 32'h0, 5'd11);
    applyStimulus(1'b0, 3'b010, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd12);
    checkRsp("lw_leds", 3, 2'd0, 32'h11223344, 5'd12);
    applyStimulus(1'b0, 3'b010, 32'h2000, 32'h0, 32'h0, 5'd13);
    checkRsp("lw_2000", 1, 2'd2, 32'h0, 5'd13);
    checkOutput("lw_2000_fault_addr", gotAddr, 32'h2000);
    applyStimulus(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 5'd14);
    checkRsp("load_f3_011", 1, 2'd2, 32'h0, 5'd14);
    applyStimulus(1'b1, 3'b101, 32'h101, 32'h0, 32'h0, 5'd15);
    checkRsp("store_f3_101_priority", 1, 2'd2, 32'h0, 5'd15);
    applyStimulus(1'b0, 3'b000, 32'hFFF, 32'h0, 32'h0, 5'd16);
    checkRsp("lb_fff", 3, 2'd0, 32'h0, 5'd16);
    applyStimulus(1'b0, 3'b000, 32'h1000, 32'h0, 32'h0, 5'd17);
    checkRsp("lb_1000", 1, 2'd2, 32'h0, 5'd17);
    checkOutput("lb_1000_fault_addr", gotAddr, 32'h1000);
    applyStimulus(1'b0, 3'b010, 32'hFFFFFFF8, 32'h0, 32'h0, 5'd18);
    checkRsp("lw_millis", 3, 2'd0, 32'h00001234, 5'd18);
    settle();
    checkOutput("cnt_after_map", {load_count, store_count, fault_count}, {20'd0, 4'd8, 4'd3, 4'd7});

    // Back-pressure holds the response.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5'd19);
    checkRsp("lw_bp", 3, 2'd0, 32'hDEADBEEF, 5'd19);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_data", rsp_data, 32'hDEADBEEF);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_dmem_wren", 32'(dmem_wren), 32'd0);
    end
    rsp_ready = 1'b1;
    settle();
    checkOutput("bp_release_req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_load_count", 32'(load_count), 32'd9);

    // Reset in the middle of a store.
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010;
    req_base = 32'h300; req_offset = 32'h0; req_store_data = 32'hAAAA5555; req_rd = 5'd20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("store_wren_high", 32'(dmem_wren), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_wren_async", 32'(dmem_wren), 32'd0);
    checkOutput("reset_rsp_valid_mid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_no_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("reset_counters_mid", {load_count, store_count, fault_count}, 32'd0);
    checkOutput("reset_store_discarded", {ram[12'h300], ram[12'h301]}, 32'd0);
    reset_n = 1'b1;
    settle();
    checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);

    // Saturation of the fault counter.
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 5'd21);
    settle();
    checkOutput("fault_count_full", 32'(fault_count), 32'd15);
    applyStimulus(1'b0, 3'b110, 32'h0, 32'h0, 32'h0, 5'd22);
    checkRsp("f3_110_sat", 1, 2'd2, 32'h0, 5'd22);
    settle();
    checkOutput("fault_count_saturated", 32'(fault_count), 32'd15);
    checkOutput("load_count_after_sat", 32'(load_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the data-memory/MMIO responder.
- Accepts one load or store at a time from the execute stage and computes the effective address.
- Checks alignment and the address map, drives the responder's dmem_* port, and captures read data after the responder's one-cycle synchronous read.
- Returns one response per request to writeback, and keeps saturating load/store/fault counters.

Parameters:
DMEM_SIZE_BYTES, 4096, size of RAM region starting at 0x0000_0000; must be a power of 2
CNT_WIDTH, 16, width of each saturating event counter

Ports:
clk  input  1  system clock; all state changes on rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  1  request presented by core
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_is_store  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V load/store funct3
req_base  input  32  rs1 value
req_offset  input  32  sign-extended immediate
req_store_data  input  32  rs2 value; low bytes used for SB/SH
req_rd  input  5  destination register tag, returned unchanged
rsp_valid  output  1  response available
rsp_ready  input  1  core consumes response
rsp_data  output  32  load result already formatted by responder; 0 for stores and faults
rsp_rd  output  5  tag of the completed request
rsp_fault  output  2  0 = none, 1 = misaligned, 2 = access fault
rsp_fault_addr  output  32  effective address of the request
dmem_address  output  32  to responder
dmem_funct3  output  3  to responder
dmem_wren  output  1  to responder; registered
dmem_data_in  output  32  store data to responder
dmem_data_out  input  32  read data from responder, valid the cycle after the address is presented
load_count, store_count, fault_count  output  CNT_WIDTH each  saturating event counters

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All registered outputs are 0: dmem_*, rsp_*, counters.
  - dmem_wren drops immediately on reset, even in mid-store; an in-flight request is discarded with no response.
- Effective address: ea = req_base + req_offset, mod 2^32. It is computed in the accept cycle.
- Misaligned (fault 1):
  - halfword (funct3[1:0]=01) with ea[0]=1;
  - word (funct3[1:0]=10) with ea[1:0]!=0.
- Illegal funct3 (fault 2):
  - loads: 011, 110, 111;
  - stores: funct3[2]=1 or funct3 = 011.
- Access fault (fault 2):
  - ea is neither below DMEM_SIZE_BYTES nor in 0xFFFF_FFF4..0xFFFF_FFFF;
  - a store to 0xFFFF_FFF4..0xFFFF_FFFB (read-only counters).
- Fault priority: illegal funct3, then misaligned, then access.
- State machine:
  - IDLE: req_ready=1. On req_valid, register ea, funct3, data and rd.
    - Faulting request → RESP, with no dmem access.
    - Store → STORE.
    - Load → LOAD_ISSUE.
  - STORE: dmem_wren=1 for exactly this one cycle, with address/funct3/data stable; → RESP.
  - LOAD_ISSUE: address/funct3 driven, dmem_wren=0. The responder samples at the end of this cycle; → LOAD_CAPTURE.
  - LOAD_CAPTURE: dmem_data_out is registered into rsp_data at the end of this cycle, with address/funct3 still held; → RESP.
  - RESP: rsp_valid=1. rsp_* stay stable until rsp_ready; on rsp_valid && rsp_ready → IDLE.
    - The next request can be accepted in the cycle after IDLE is re-entered; there is no bypass.
- Latency from accept edge to rsp_valid:
  - store 2 cycles;
  - load 3 cycles;
  - fault 1 cycle.
- dmem_address and dmem_funct3 hold their last values outside active states. dmem_wren is 0 in every state except STORE.
- Counters: increment on RESP handshake by category (load/store on success, fault_count on any fault). They hold at all-ones (saturate, no wrap).
- Back-pressure: rsp_ready low holds RESP indefinitely, with no further dmem activity.

Decomposition:
- Package lsu_pkg: state enum (IDLE, STORE, LOAD_ISSUE, LOAD_CAPTURE, RESP); fault code constants; funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW); MMIO base constants (0xFFFF_FFFC leds, 0xFFFF_FFF8 millis, 0xFFFF_FFF4 micros).
- Sub-module lsu_addr_check: combinational; inputs ea, funct3, is_store; output fault code. Unit-testable on its own.

Test Plan:
- SW base=0x100 offset=4 data=0xDEADBEEF, then LW same ea → dmem_wren high exactly 1 cycle at 0x104; load rsp_data=0xDEADBEEF 3 cycles after accept; store_count=1, load_count=1.
- SB 0x80 at ea 0x203, then LB/LBU 0x203 → LB rsp_data=0xFFFFFF80, LBU rsp_data=0x00000080.
- LW ea=0x102 and LH ea=0x101 → rsp_fault=1 after 1 cycle, dmem_wren never asserted, fault_count=2.
- SW ea=0xFFFFFFF8 → rsp_fault=2. SW 0x11223344 to 0xFFFFFFFC, then LW 0xFFFFFFFC → 0x11223344. LW ea=0x00002000 → rsp_fault=2.
- rsp_ready held low 5 cycles after a load → rsp_valid and rsp_data stable, req_ready=0; after release, IDLE and req_ready=1 next cycle.
- reset_n asserted during STORE → dmem_wren=0 asynchronously, no rsp_valid; after release, state IDLE; force counter to all-ones → next event leaves it at all-ones.
